// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, opcodes,
// FSM state encoding and the funct3 legality helper.
package lsu_pkg;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Stores only know SB/SH/SW; loads additionally have LBU/LHU.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 > SW;
        end
        return (f3 == 3'd3) || (f3 > LHU);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port byte-enabled RAM, one array per byte lane, synchronous write
// and registered read (data for the address presented at an edge appears after it).
module dmem_bank #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (be[gi]) begin
                    mem[addr] <= wdata[8*gi +: 8];
                end
                rd_reg <= mem[addr];
            end

            assign rdata[8*gi +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/lsu_dmem_resp.sv
// Data-memory responder: valid/ready request, WAIT_STATES wait cycles, byte/half/word
// access on dmem_bank, one-cycle registered response. Optional macro: MISALIGN_TRAP_EN.
module lsu_dmem_resp
    import lsu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic             we_reg;
    logic [2:0]       funct3_reg;
    logic [AW+1:0]    addr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic             resp_valid_reg;
    logic [WIDTH-1:0] resp_rdata_reg;
    logic             resp_err_reg;

    logic [1:0]       lo;
    logic             acc_err;
    logic [3:0]       be;
    logic [3:0]       ram_be;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] load_data;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [AW-1:0]    ram_addr;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^req_addr[WIDTH-1:AW+2];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (req_valid) state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (cnt_reg == '0) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            resp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE:   if (req_valid) cnt_reg <= CNT_LOAD;
                ST_WAIT:   if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
                ST_ACCESS: begin
                    resp_valid_reg <= 1'b1;
                    resp_err_reg   <= acc_err;
                    resp_rdata_reg <= (acc_err || we_reg) ? '0 : load_data;
                end
                default: ;
            endcase
        end
    end

    // Request fields are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_reg == ST_IDLE && req_valid) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr[AW+1:0];
            wdata_reg  <= req_wdata;
        end
    end

    assign lo = addr_reg[1:0];

    always_comb begin
        acc_err = f3_illegal(we_reg, funct3_reg);
`ifdef MISALIGN_TRAP_EN
        if ((funct3_reg[1:0] == 2'b01 && lo[0]) || (funct3_reg[1:0] == 2'b10 && lo != 2'b00)) begin
            acc_err = 1'b1;
        end
`endif
        be      = 4'b0000;
        wr_data = wdata_reg;
        // Without the trap, halfword ignores lo[0] and word ignores lo entirely.
        case (funct3_reg[1:0])
            2'b00: begin
                be      = 4'b0001 << lo;
                wr_data = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                be      = lo[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_reg[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        byte_sel  = rd_data[{lo, 3'b000} +: 8];
        half_sel  = lo[1] ? rd_data[31:16] : rd_data[15:0];
        load_data = '0;
        case (funct3_reg)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LH:      load_data = {{16{half_sel[15]}}, half_sel};
            LW:      load_data = rd_data;
            LBU:     load_data = {24'd0, byte_sel};
            LHU:     load_data = {16'd0, half_sel};
            default: load_data = '0;
        endcase
    end

    // Gating with rst drops a store whose ACCESS edge coincides with reset.
    assign ram_be   = (state_reg == ST_ACCESS && we_reg && !acc_err && rst) ? be : 4'b0000;
    // In IDLE the incoming address is presented so read data is ready in ACCESS
    // even with zero wait states.
    assign ram_addr = (state_reg == ST_IDLE) ? req_addr[AW+1:2] : addr_reg[AW+1:2];

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_bank (
        .clk  (clk),
        .be   (ram_be),
        .addr (ram_addr),
        .wdata(wr_data),
        .rdata(rd_data)
    );

    assign req_ready  = (state_reg == ST_IDLE);
    assign busy       = (state_reg != ST_IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: doc/lsu_dmem_resp.md
Name: lsu_dmem_resp

Overview:
Data-memory responder for the single-cycle RISC-V datapath; it receives the load/store effective address computed by the ALU (Mem_addr) and performs the access.
- Accepts one request per valid/ready handshake.
- Inserts configurable wait states.
- Performs byte/half/word access on an internal byte-enabled RAM.
- Returns sign- or zero-extended load data with a one-cycle response pulse.
- busy stalls the core's PC while an access is in flight.

Parameters:
WIDTH, 32, data/address width
DEPTH_WORDS, 256, RAM depth in 32-bit words (power of two)
WAIT_STATES, 1, extra cycles between accept and RAM access (0 allowed)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width/sign code
req_addr  in  WIDTH  effective byte address (ALU Mem_addr)
req_wdata  in  WIDTH  store data (RS2)
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  WIDTH  load result, 0 for stores/errors
resp_err  out  1  illegal funct3 (or misalignment, see macro), valid with resp_valid
busy  out  1  high from accept through the RESP cycle inclusive

Behaviour:
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata and go to WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: down-counter loaded with WAIT_STATES-1; go to ACCESS when it reaches 0.
- ACCESS:
  - Store: write enabled byte lanes.
  - Load: read word and format it.
  - Go to RESP.
- RESP: resp_valid=1 for exactly one cycle, outputs registered; return to IDLE. No request is accepted in RESP.
- Latency: accept at edge N gives resp_valid high in cycle N+2+WAIT_STATES.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Loads:
  - LB=0 / LBU=4: lane addr[1:0], sign- or zero-extended.
  - LH=1 / LHU=5: lane addr[1], sign- or zero-extended.
  - LW=2: full word.
- Stores:
  - SB=0: byte enable 1<<addr[1:0], data byte replicated.
  - SH=1: enables 0011 or 1100 by addr[1].
  - SW=2: enables 1111.
- Illegal funct3 (loads 3,6,7; stores 3-7): resp_err=1, resp_rdata=0, no RAM write.
- Store response: resp_rdata=0, resp_err=0 unless illegal.
- Back-to-back store then load to the same address returns the new data; the write commits in ACCESS, before any later access.
- req_valid outside IDLE is ignored; the core holds the request via busy.
- Reset values: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; busy 0, req_ready 1 after the reset edge.
- RAM contents are not reset.
- Reset mid-operation: an in-flight request is discarded and no resp_valid is produced. A store is not written if reset is asserted at or before its ACCESS edge.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, yields resp_err=1, resp_rdata=0, no write.
  - Latency is unchanged.
- Undefined: low address bits are forced to natural alignment (addr[0] for halfword, addr[1:0] for word); no error.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams LB/LH/LW/LBU/LHU/SB/SH/SW.
  - FSM state encoding.
  - opcode constants LOAD=7'b0000011, STORE=7'b0100011.
- Sub-module dmem_bank:
  - Single-port DEPTH_WORDS x 32 RAM, 4-bit byte enable, synchronous write.
  - Read data valid in the ACCESS cycle.
- Lane select and extension logic stays in the top module.

Test Plan:
1. SW 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0; resp_valid exactly 2+WAIT_STATES cycles after each accept; busy high through RESP.
2. After case 1, SB 0x13 data 0x00000080 -> LW 0x10 = 0x80ADBEEF; LB 0x13 = 0xFFFFFF80; LBU 0x13 = 0x00000080.
3. SW 0x20 0xDEADBEEF, SH 0x22 0x00001234 -> LW 0x20 = 0x1234BEEF; LH 0x20 = 0xFFFFBEEF; LHU 0x22 = 0x00001234.
4. LW 0x11 -> with MISALIGN_TRAP_EN, err 1 and rdata 0; without, rdata equals LW 0x10. Load funct3=3 -> err 1, rdata 0 in both builds.
5. WAIT_STATES=2: accept SW 0x30 0x11111111, drive rst=0 the next cycle -> no resp_valid; after release, LW 0x30 returns the prior value.
6. DEPTH_WORDS=256: SW 0x400 0xCAFEF00D -> LW 0x000 = 0xCAFEF00D (wrap). req_valid held during busy -> only one response.
